// File: rtl/vec_ctrl_sequencer.sv
// rtl/vec_ctrl_sequencer.sv - multi-cycle control sequencer for the vector alpha-composition ASIP
// Decodes {op,inst} at accept and sequences EXEC (one cycle) or MEM (NUM_BEATS handshaked beats).
module vec_ctrl_sequencer #(
  parameter int   NUM_BEATS = 4,
  localparam int  BEAT_W    = ($clog2(NUM_BEATS) > 1) ? $clog2(NUM_BEATS) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_instr_valid,
  output logic              o_instr_ready,
  input  logic [1:0]        i_op,
  input  logic [1:0]        i_inst,
  input  logic              i_flagV,
  input  logic              i_mem_ready,
  output logic              o_wmem,
  output logic              o_rmem,
  output logic              o_wreg,
  output logic [1:0]        o_jmpF,
  output logic              o_jmpSel,
  output logic              o_CondEn,
  output logic              o_VF,
  output logic [BEAT_W-1:0] o_beat_idx,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM} state_t;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

  state_t            r_state;
  logic              r_wmem;
  logic              r_rmem;
  logic              r_wreg;
  logic [1:0]        r_jmpf;
  logic              r_cond;
  logic              r_vf;
  logic              r_done;
  logic [BEAT_W-1:0] r_beat;

  logic w_store;
  logic w_load;
  logic w_cond;
  logic w_jmp_any;
  logic w_jeq;
  logic w_last_beat;
  logic w_beat_fire;

  assign w_store     = (i_op == 2'b01) && (i_inst == 2'b00);
  assign w_load      = (i_op == 2'b11) && (i_inst == 2'b01);
  assign w_cond      = (i_op == 2'b01) && (i_inst != 2'b00);
  assign w_jmp_any   = (i_op == 2'b00) && !i_inst[1];
  assign w_jeq       = (i_op == 2'b00) && (i_inst == 2'b01);
  assign w_last_beat = (r_beat == LAST_BEAT);
  assign w_beat_fire = (r_state == S_MEM) && i_mem_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_wmem  <= 1'b0;
      r_rmem  <= 1'b0;
      r_wreg  <= 1'b0;
      r_jmpf  <= 2'b00;
      r_cond  <= 1'b0;
      r_vf    <= 1'b0;
      r_done  <= 1'b0;
      r_beat  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_instr_valid) begin
            r_vf <= i_flagV;
            if (w_store || w_load) begin
              r_state <= S_MEM;
              r_wmem  <= w_store;
              r_rmem  <= w_load;
              r_wreg  <= w_load;
            end else begin
              // Conditional ops are predicated by the flag captured here, not the live one
              r_state <= S_EXEC;
              r_wreg  <= i_op[1] | (w_cond & i_flagV);
              r_jmpf  <= {w_jeq, w_jmp_any};
              r_cond  <= w_cond;
              r_done  <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          r_state <= S_IDLE;
          r_wreg  <= 1'b0;
          r_jmpf  <= 2'b00;
          r_cond  <= 1'b0;
          r_vf    <= 1'b0;
          r_done  <= 1'b0;
        end
        S_MEM: begin
          if (i_mem_ready) begin
            if (w_last_beat) begin
              r_state <= S_IDLE;
              r_wmem  <= 1'b0;
              r_rmem  <= 1'b0;
              r_wreg  <= 1'b0;
              r_vf    <= 1'b0;
              r_beat  <= '0;
            end else begin
              r_beat <= r_beat + BEAT_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The final beat retires in the same cycle memory accepts it
  assign o_done        = r_done | (w_beat_fire & w_last_beat);
  assign o_instr_ready = (r_state == S_IDLE);
  assign o_busy        = (r_state != S_IDLE);
  assign o_wmem        = r_wmem;
  assign o_rmem        = r_rmem;
  assign o_wreg        = r_wreg;
  assign o_jmpF        = r_jmpf;
  assign o_jmpSel      = r_jmpf[1] | r_jmpf[0];
  assign o_CondEn      = r_cond;
  assign o_VF          = r_vf;
  assign o_beat_idx    = r_beat;

endmodule

// File: tb/tb_vec_ctrl_sequencer.sv
// tb/tb_vec_ctrl_sequencer.sv - self-checking bench for vec_ctrl_sequencer
module tb_vec_ctrl_sequencer;
  localparam int NB = 4;
  localparam int BW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_valid;
  logic          instr_ready;
  logic [1:0]    op;
  logic [1:0]    inst;
  logic          flagV;
  logic          mem_ready;
  logic          wmem, rmem, wreg, jmpSel, CondEn, VF, busy, done;
  logic [1:0]    jmpF;
  logic [BW-1:0] beat_idx;

  int vectors     = 0;
  int miscompares = 0;
  bit run         = 1'b0;

  always #5 clk = ~clk;

  vec_ctrl_sequencer #(.NUM_BEATS(NB)) dut (
    .i_clk(clk), .i_rst(rst), .i_instr_valid(instr_valid), .o_instr_ready(instr_ready),
    .i_op(op), .i_inst(inst), .i_flagV(flagV), .i_mem_ready(mem_ready),
    .o_wmem(wmem), .o_rmem(rmem), .o_wreg(wreg), .o_jmpF(jmpF), .o_jmpSel(jmpSel),
    .o_CondEn(CondEn), .o_VF(VF), .o_beat_idx(beat_idx), .o_busy(busy), .o_done(done)
  );

  // Instruction-level model: what is in flight, which beat, captured flag
  bit m_busy = 0;
  bit m_mem  = 0;
  bit m_vf   = 0;
  int m_code = 0;
  int m_beat = 0;

  function automatic logic [12:0] expect_vec(input logic mr);
    logic st, ld, jeq, jany, cnd, wr;
    st   = (m_code == 4);
    ld   = (m_code == 13);
    jeq  = (m_code == 1);
    jany = (m_code <= 1);
    cnd  = (m_code >= 5) && (m_code <= 7);
    if (!m_busy)
      return {1'b1, 12'b0};
    if (!m_mem) begin
      wr = (m_code >= 8) || (cnd && m_vf);
      return {1'b0, 1'b1, 1'b0, 1'b0, wr, jeq, jany, jany, cnd, m_vf, 2'b00, 1'b1};
    end
    return {1'b0, 1'b1, st, ld, ld, 2'b00, 1'b0, 1'b0, m_vf, BW'(m_beat),
            mr && (m_beat == NB - 1)};
  endfunction

  always @(negedge clk) begin
    if (run) begin
      logic [12:0] exp_v, act_v;
      #4;
      if (rst) begin
        m_busy = 0; m_mem = 0; m_vf = 0; m_beat = 0;
      end
      exp_v = expect_vec(mem_ready);
      act_v = {instr_ready, busy, wmem, rmem, wreg, jmpF, jmpSel, CondEn, VF, beat_idx, done};
      vectors++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL cycle_outputs t=%0t actual=%b expected=%b", $time, act_v, exp_v);
      end
      if (!rst) begin
        if (!m_busy) begin
          if (instr_valid) begin
            m_busy = 1;
            m_code = int'({op, inst});
            m_vf   = flagV;
            m_mem  = (m_code == 4) || (m_code == 13);
            m_beat = 0;
          end
        end else if (!m_mem) begin
          m_busy = 0;
        end else if (mem_ready) begin
          if (m_beat == NB - 1) begin
            m_busy = 0; m_beat = 0;
          end else begin
            m_beat++;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic lit(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [1:0] i, input logic fv);
    instr_valid = 1'b1; op = o; inst = i; flagV = fv;
    cyc();
    instr_valid = 1'b0;
  endtask

  initial begin
    int pat [6] = '{1, 0, 0, 1, 1, 1};
    int eb  [6] = '{0, 1, 1, 1, 2, 3};
    rst = 1'b1; instr_valid = 1'b0; op = 2'b00; inst = 2'b00; flagV = 1'b0; mem_ready = 1'b1;
    run = 1'b1;
    cyc();
    #2;
    lit("reset_ready", int'(instr_ready), 1);
    lit("reset_busy", int'(busy), 0);
    lit("reset_beat", int'(beat_idx), 0);
    cyc();
    rst = 1'b0;
    cyc();

    // ALU op writes the register file for exactly one cycle
    issue(2'b10, 2'b11, 1'b0);
    #2;
    lit("alu_wreg", int'(wreg), 1);
    lit("alu_done", int'(done), 1);
    lit("alu_busy", int'(busy), 1);
    cyc();
    #2;
    lit("alu_ready_after", int'(instr_ready), 1);
    lit("alu_busy_after", int'(busy), 0);
    cyc();

    // STORE, memory always ready
    issue(2'b01, 2'b00, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #2;
      lit("store_wmem", int'(wmem), 1);
      lit("store_beat", int'(beat_idx), k);
      lit("store_done", int'(done), (k == 3) ? 1 : 0);
      cyc();
    end
    #2;
    lit("store_idle", int'(busy), 0);
    cyc();

    // LOAD with stalls
    mem_ready = 1'b0;
    issue(2'b11, 2'b01, 1'b0);
    for (int k = 0; k < 6; k++) begin
      mem_ready = pat[k][0];
      #2;
      lit("load_rmem", int'(rmem), 1);
      lit("load_wreg", int'(wreg), 1);
      lit("load_beat", int'(beat_idx), eb[k]);
      lit("load_done", int'(done), (k == 5) ? 1 : 0);
      cyc();
    end
    mem_ready = 1'b1;
    #2;
    lit("load_idle", int'(busy), 0);
    cyc();

    // Conditional op predication and flag capture
    issue(2'b01, 2'b10, 1'b0);
    #2;
    lit("cond0_en", int'(CondEn), 1);
    lit("cond0_vf", int'(VF), 0);
    lit("cond0_wreg", int'(wreg), 0);
    lit("cond0_done", int'(done), 1);
    cyc();
    issue(2'b01, 2'b10, 1'b1);
    flagV = 1'b0;
    #2;
    lit("cond1_wreg", int'(wreg), 1);
    lit("cond1_vf_held", int'(VF), 1);
    cyc();

    // Jumps and an undefined encoding
    issue(2'b00, 2'b01, 1'b0);
    #2;
    lit("jeq_jmpF", int'(jmpF), 3);
    lit("jeq_sel", int'(jmpSel), 1);
    cyc();
    issue(2'b00, 2'b00, 1'b0);
    #2;
    lit("jmp_jmpF", int'(jmpF), 1);
    cyc();
    issue(2'b00, 2'b10, 1'b0);
    #2;
    lit("nojmp_jmpF", int'(jmpF), 0);
    lit("nojmp_done", int'(done), 1);
    cyc();
    issue(2'b00, 2'b11, 1'b0);
    #2;
    lit("undef_wreg", int'(wreg), 0);
    lit("undef_done", int'(done), 1);
    cyc();

    // Asynchronous reset in the middle of a STORE
    issue(2'b01, 2'b00, 1'b0);
    cyc();
    mem_ready = 1'b0;
    #1;
    lit("abort_pre_beat", int'(beat_idx), 1);
    rst = 1'b1;
    #1;
    lit("abort_wmem", int'(wmem), 0);
    lit("abort_beat", int'(beat_idx), 0);
    lit("abort_ready", int'(instr_ready), 1);
    lit("abort_done", int'(done), 0);
    cyc();
    rst = 1'b0;
    mem_ready = 1'b1;
    cyc();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 299) == 0);
      instr_valid = ($urandom_range(0, 2) != 0);
      op          = 2'($urandom_range(0, 3));
      inst        = 2'($urandom_range(0, 3));
      flagV       = 1'($urandom_range(0, 1));
      mem_ready   = ($urandom_range(0, 3) != 0);
      cyc();
    end
    rst = 1'b0; instr_valid = 1'b0; mem_ready = 1'b1;
    repeat (8) cyc();
    run = 1'b0;
    #20;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
